// File: rtl/mig_port_arbiter_if.sv
// Client-port and MIG app-interface bundle for mig_port_arbiter.
// master = the arbiter; slave = the clients together with the MIG user interface.
interface mig_port_arbiter_if #(
    parameter int NUM_PORTS  = 5,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 27
);
    logic                            init_calib_complete;
    logic [NUM_PORTS-1:0]            req;
    logic [NUM_PORTS-1:0]            req_we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            ack;
    logic [NUM_PORTS-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]           rd_data;
    logic [ADDR_WIDTH-1:0]           app_addr;
    logic [2:0]                      app_cmd;
    logic                            app_en;
    logic                            app_rdy;
    logic [DATA_WIDTH-1:0]           app_wdf_data;
    logic                            app_wdf_end;
    logic                            app_wdf_wren;
    logic [DATA_WIDTH/8-1:0]         app_wdf_mask;
    logic                            app_wdf_rdy;
    logic [DATA_WIDTH-1:0]           app_rd_data;
    logic                            app_rd_data_valid;
    logic                            app_rd_data_end;
    logic                            app_hi_pri;
    logic                            rd_overflow;
    logic [NUM_PORTS*16-1:0]         stat_grants;

    modport master (
        input  init_calib_complete, req, req_we, req_addr, req_wdata,
               app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
        output ack, rd_valid, rd_data, app_addr, app_cmd, app_en,
               app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
               app_hi_pri, rd_overflow, stat_grants
    );

    modport slave (
        output init_calib_complete, req, req_we, req_addr, req_wdata,
               app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  ack, rd_valid, rd_data, app_addr, app_cmd, app_en,
               app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
               app_hi_pri, rd_overflow, stat_grants
    );
endinterface

// File: rtl/mig_port_arbiter.sv
// N-port two-class round-robin arbiter onto the MIG app interface with read-tag return routing.
// Optional per-port grant counters when ARB_STATS_EN is defined.
module mig_port_arbiter #(
    parameter int                   NUM_PORTS  = 5,
    parameter int                   DATA_WIDTH = 128,
    parameter int                   ADDR_WIDTH = 27,
    parameter int                   RD_DEPTH   = 16,
    parameter logic [NUM_PORTS-1:0] PRIO_MASK  = 5'b00010
) (
    input  logic               ui_clk,
    input  logic               rst_n,
    mig_port_arbiter_if.master bus
);
    localparam int         IW     = $clog2(NUM_PORTS);
    localparam int         PW     = $clog2(RD_DEPTH);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CMD  = 1'b1;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    logic [0:0]                  r_state;
    logic [IW-1:0]               r_idx;
    logic [2:0]                  r_cmd;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [DATA_WIDTH-1:0]       r_wdata;
    logic                        r_cmd_done;
    logic                        r_wdf_done;
    logic [IW-1:0]               r_ptr_hi;
    logic [IW-1:0]               r_ptr_lo;
    logic [RD_DEPTH-1:0][IW-1:0] r_tag;
    logic [PW-1:0]               r_wp;
    logic [PW-1:0]               r_rp;
    logic [PW:0]                 r_cnt;
    logic [NUM_PORTS-1:0]        r_rd_valid;
    logic [DATA_WIDTH-1:0]       r_rd_data;
    logic                        r_ovf;

    logic                 w_full, w_use_hi, w_gnt, w_push, w_pop, w_done;
    logic                 w_app_en, w_wdf_wren;
    logic [NUM_PORTS-1:0] w_elig, w_cls, w_ack;
    logic [IW-1:0]        w_ptr, w_gidx, w_gnext;
    logic                 w_unused;

    assign w_unused = bus.app_rd_data_end;
    assign w_full   = (r_cnt == (PW+1)'(RD_DEPTH));
    // Writes never occupy a tag, so they stay eligible while reads are throttled.
    assign w_elig   = bus.req & {NUM_PORTS{bus.init_calib_complete}} &
                      (bus.req_we | {NUM_PORTS{~w_full}});
    assign w_use_hi = |(w_elig & PRIO_MASK);
    assign w_cls    = w_use_hi ? (w_elig & PRIO_MASK) : (w_elig & ~PRIO_MASK);
    assign w_ptr    = w_use_hi ? r_ptr_hi : r_ptr_lo;

    // Scan downwards so the smallest offset from the pointer wins last.
    always_comb begin
        int j;
        j      = 0;
        w_gnt  = 1'b0;
        w_gidx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            j = int'(w_ptr) + k;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (w_cls[j]) begin
                w_gnt  = 1'b1;
                w_gidx = IW'(j);
            end
        end
    end

    assign w_gnext = (w_gidx == IW'(NUM_PORTS - 1)) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cmd      <= CMD_WR;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cmd_done <= 1'b0;
            r_wdf_done <= 1'b0;
            r_ptr_hi   <= '0;
            r_ptr_lo   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_gnt) begin
                    r_state    <= S_CMD;
                    r_idx      <= w_gidx;
                    r_cmd      <= bus.req_we[w_gidx] ? CMD_WR : CMD_RD;
                    r_addr     <= bus.req_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH];
                    r_wdata    <= bus.req_wdata[w_gidx*DATA_WIDTH +: DATA_WIDTH];
                    r_cmd_done <= 1'b0;
                    r_wdf_done <= ~bus.req_we[w_gidx];
                    if (w_use_hi) r_ptr_hi <= w_gnext;
                    else          r_ptr_lo <= w_gnext;
                end
                default: if (r_cmd_done && r_wdf_done) begin
                    r_state <= S_IDLE;
                end else begin
                    if (w_app_en && bus.app_rdy)        r_cmd_done <= 1'b1;
                    if (w_wdf_wren && bus.app_wdf_rdy)  r_wdf_done <= 1'b1;
                end
            endcase
        end
    end

    assign w_done     = (r_state == S_CMD) & r_cmd_done & r_wdf_done;
    assign w_app_en   = (r_state == S_CMD) & ~r_cmd_done;
    assign w_wdf_wren = (r_state == S_CMD) & ~r_wdf_done;

    always_comb begin
        w_ack = '0;
        if (w_done) w_ack[r_idx] = 1'b1;
    end

    // Tag FIFO: issuing port of every accepted read, popped in MIG return order.
    assign w_push = w_app_en & bus.app_rdy & (r_cmd == CMD_RD);
    assign w_pop  = bus.app_rd_data_valid & (r_cnt != '0);

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag      <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) begin
                r_tag[r_wp] <= r_idx;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt      <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
            r_rd_valid <= '0;
            if (w_pop) r_rd_valid[r_tag[r_rp]] <= 1'b1;
            if (bus.app_rd_data_valid) r_rd_data <= bus.app_rd_data;
            if (bus.app_rd_data_valid && r_cnt == '0) r_ovf <= 1'b1;
        end
    end

    assign bus.ack          = w_ack;
    assign bus.app_en       = w_app_en;
    assign bus.app_cmd      = r_cmd;
    assign bus.app_addr     = r_addr;
    assign bus.app_wdf_data = r_wdata;
    assign bus.app_wdf_wren = w_wdf_wren;
    assign bus.app_wdf_end  = w_wdf_wren;
    assign bus.app_wdf_mask = '0;
    assign bus.app_hi_pri   = 1'b0;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.rd_data      = r_rd_data;
    assign bus.rd_overflow  = r_ovf;

`ifdef ARB_STATS_EN
    logic [NUM_PORTS-1:0][15:0] r_stat;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                if (w_ack[i] && r_stat[i] != 16'hFFFF) r_stat[i] <= r_stat[i] + 16'd1;
        end
    end

    assign bus.stat_grants = r_stat;
`else
    assign bus.stat_grants = '0;
`endif
endmodule

// File: tb/tb_mig_port_arbiter.sv
// Directed plus randomized bench for mig_port_arbiter against a transaction-level model.
module tb_mig_port_arbiter;
    localparam int             NP = 5;
    localparam int             DW = 128;
    localparam int             AW = 27;
    localparam int             RD = 4;
    localparam logic [NP-1:0]  PM = 5'b00010;

    logic ui_clk = 1'b0;
    logic rst_n  = 1'b1;
    always #5 ui_clk = ~ui_clk;

    mig_port_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mig_port_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_DEPTH(RD), .PRIO_MASK(PM)
    ) dut (
        .ui_clk(ui_clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- behavioural model (transaction level) ----------------
    bit          m_busy, m_we, m_cd, m_wd, m_ovf;
    int          m_idx, m_ptr_hi, m_ptr_lo;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdd   = '0;
    logic [NP-1:0] m_rdv   = '0;
    int          m_q[$];
    int          m_cnt[NP];

    initial forever begin
        @(posedge ui_clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0; m_ptr_hi = 0; m_ptr_lo = 0; m_ovf = 0;
            m_rdv = '0; m_rdd = '0; m_q.delete();
            for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        end else begin
            bit          full, push, use_hi;
            bit [NP-1:0] elig;
            int          g, j;
            full = (m_q.size() == RD);
            push = 0;
            if (m_busy) begin
                if (m_cd && m_wd) begin
                    m_busy = 0;
                    if (m_cnt[m_idx] < 65535) m_cnt[m_idx]++;
                end else begin
                    if (!m_cd && bus.app_rdy)     begin m_cd = 1; push = !m_we; end
                    if (!m_wd && bus.app_wdf_rdy) m_wd = 1;
                end
            end else begin
                for (int i = 0; i < NP; i++)
                    elig[i] = bus.req[i] && bus.init_calib_complete && (bus.req_we[i] || !full);
                use_hi = (elig & PM) != 0;
                g = -1;
                for (int k = 0; k < NP; k++) begin
                    j = ((use_hi ? m_ptr_hi : m_ptr_lo) + k) % NP;
                    if (g < 0 && elig[j] && (PM[j] == use_hi)) g = j;
                end
                if (g >= 0) begin
                    m_busy = 1; m_idx = g; m_we = bus.req_we[g];
                    m_addr  = bus.req_addr[g*AW +: AW];
                    m_wdata = bus.req_wdata[g*DW +: DW];
                    m_cd = 0; m_wd = !m_we;
                    if (use_hi) m_ptr_hi = (g + 1) % NP;
                    else        m_ptr_lo = (g + 1) % NP;
                end
            end
            m_rdv = '0;
            if (bus.app_rd_data_valid) begin
                if (m_q.size() > 0) begin
                    m_rdv[m_q.pop_front()] = 1'b1;
                    m_rdd = bus.app_rd_data;
                end else m_ovf = 1;
            end
            if (push) m_q.push_back(m_idx);
        end
    end

    // ---------------- compare + monitor (negedge) ----------------
    bit            chk_on = 0;
    int            cyc_n = 0, en_cnt = 0, wren_cnt = 0, acc_cyc = 0, ack_cyc = 0;
    logic [NP-1:0] last_ack = '0;
    int            ack_log[$];
    logic [NP-1:0] rv_log[$];
    logic [DW-1:0] rd_log[$];

    always @(negedge ui_clk) begin
        logic [NP-1:0]    eack;
        logic [NP*16-1:0] estat;
        bit               een, ewr;
        cyc_n++;
        last_ack = bus.ack;
        for (int i = 0; i < NP; i++) if (bus.ack[i]) ack_log.push_back(i);
        if (bus.ack != '0) ack_cyc = cyc_n;
        if (bus.rd_valid != '0) begin rv_log.push_back(bus.rd_valid); rd_log.push_back(bus.rd_data); end
        if (bus.app_en) en_cnt++;
        if (bus.app_wdf_wren) wren_cnt++;
        if (bus.app_en && bus.app_rdy) acc_cyc = cyc_n;
        if (chk_on) begin
            een  = m_busy && !m_cd;
            ewr  = m_busy && !m_wd;
            eack = '0;
            if (m_busy && m_cd && m_wd) eack[m_idx] = 1'b1;
            estat = '0;
`ifdef ARB_STATS_EN
            for (int i = 0; i < NP; i++) estat[i*16 +: 16] = m_cnt[i][15:0];
`endif
            chk("app_en", bus.app_en, een);
            chk("app_wdf_wren", bus.app_wdf_wren, ewr);
            chk("app_wdf_end", bus.app_wdf_end, ewr);
            chk("ack", bus.ack, eack);
            chk("rd_valid", bus.rd_valid, m_rdv);
            chk("rd_overflow", bus.rd_overflow, m_ovf);
            chk("wdf_mask/hi_pri", {bus.app_wdf_mask, bus.app_hi_pri}, '0);
            chk("stat_grants", bus.stat_grants, estat);
            if (een) begin
                chk("app_cmd", bus.app_cmd, m_we ? 3'b000 : 3'b001);
                chk("app_addr", bus.app_addr, m_addr);
            end
            if (ewr) chk("app_wdf_data", bus.app_wdf_data, m_wdata);
            if (m_rdv != '0) chk("rd_data", bus.rd_data, m_rdd);
            if (!rst_n) chk("reset outputs", {bus.app_addr, bus.app_cmd, bus.app_wdf_data, bus.rd_data}, '0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge ui_clk);
        #1;
        bus.req = bus.req & ~last_ack;
    endtask

    task automatic wait_ack(input int p, input string nm);
        int n;
        n = 0;
        do begin step(); n++; end while (!last_ack[p] && n < 40);
        if (!last_ack[p]) chk({nm, " ack timeout"}, last_ack[p], 1'b1);
    endtask

    task automatic do_reset();
        @(posedge ui_clk);
        #1;
        rst_n = 1'b0;
        bus.req = '0;
        bus.app_rd_data_valid = 1'b0;
        repeat (2) @(posedge ui_clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_port(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_we[p] = we;
        bus.req_addr[p*AW +: AW] = a;
        bus.req_wdata[p*DW +: DW] = d;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired after %0d cycles", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          a0, r0, w0;
        bit          found;
        logic [2:0]  cmd_s;
        logic [AW-1:0] addr_s;
        logic [DW-1:0] dd[3];
        int          exp_ord[6];
        logic [NP-1:0] exp_rv[3];

        bus.init_calib_complete = 0; bus.req = '0; bus.req_we = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.app_rdy = 0; bus.app_wdf_rdy = 0;
        bus.app_rd_data = '0; bus.app_rd_data_valid = 0; bus.app_rd_data_end = 0;
        #2 rst_n = 1'b0;
        #1 chk_on = 1;
        chk("reset state", {bus.app_en, bus.app_wdf_wren, bus.ack, bus.rd_valid, bus.rd_overflow, bus.app_cmd}, '0);
        repeat (2) @(posedge ui_clk);
        #1 rst_n = 1'b1;

        // calibration gate
        bus.app_rdy = 1; bus.app_wdf_rdy = 1;
        set_port(0, 0, 27'h0ABCDE, '0);
        bus.req = 5'b00001;
        w0 = en_cnt;
        repeat (5) step();
        chk("calib gate app_en count", en_cnt - w0, 0);
        bus.init_calib_complete = 1;
        found = 0; cmd_s = '0; addr_s = '0;
        repeat (2) begin
            @(negedge ui_clk);
            if (!found && bus.app_en) begin found = 1; cmd_s = bus.app_cmd; addr_s = bus.app_addr; end
        end
        chk("calib app_en within 2", found, 1'b1);
        chk("calib app_cmd", cmd_s, 3'b001);
        chk("calib app_addr", addr_s, 27'h0ABCDE);
        wait_ack(0, "calib");

        // priority + round robin
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 1, AW'(p * 16), rnd128());
        a0 = ack_log.size();
        bus.req = 5'b11101;
        step();
        bus.req[1] = 1'b1;
        repeat (22) begin step(); bus.req = bus.req | 5'b11101; end
        exp_ord = '{0, 1, 2, 3, 4, 0};
        chk("prio ack count", ack_log.size() >= a0 + 6, 1'b1);
        for (int k = 0; k < 6; k++)
            if (ack_log.size() > a0 + k) chk($sformatf("prio order %0d", k), ack_log[a0 + k], exp_ord[k]);

        // write handshake: data accepted three cycles before command
        do_reset();
        bus.app_rdy = 0; bus.app_wdf_rdy = 1;
        set_port(2, 1, 27'h100, {16{8'hA5}});
        bus.req = 5'b00100;
        w0 = wren_cnt;
        step();
        repeat (3) step();
        bus.app_rdy = 1;
        wait_ack(2, "wr");
        chk("wr wren once", wren_cnt - w0, 1);
        chk("wr ack latency", ack_cyc - acc_cyc, 1);

        // read routing 3, 0, 3
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 0, AW'($urandom), '0);
        bus.req[3] = 1; wait_ack(3, "rd3a");
        bus.req[0] = 1; wait_ack(0, "rd0");
        bus.req[3] = 1; wait_ack(3, "rd3b");
        r0 = rv_log.size();
        exp_rv = '{5'b01000, 5'b00001, 5'b01000};
        for (int k = 0; k < 3; k++) begin
            dd[k] = rnd128();
            bus.app_rd_data = dd[k]; bus.app_rd_data_valid = 1;
            step();
        end
        bus.app_rd_data_valid = 0;
        repeat (2) step();
        chk("rd route count", rv_log.size() - r0, 3);
        for (int k = 0; k < 3; k++)
            if (rv_log.size() > r0 + k) begin
                chk($sformatf("rd route pattern %0d", k), rv_log[r0 + k], exp_rv[k]);
                chk($sformatf("rd route data %0d", k), rd_log[r0 + k], dd[k]);
            end

        // tag FIFO full: read on hi port stalls, write on lo port proceeds
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 0, AW'($urandom), '0);
        bus.req[0] = 1; wait_ack(0, "f0");
        bus.req[2] = 1; wait_ack(2, "f2");
        bus.req[3] = 1; wait_ack(3, "f3");
        bus.req[0] = 1; wait_ack(0, "f0b");
        set_port(4, 1, 27'h55, rnd128());
        a0 = ack_log.size();
        bus.req = 5'b10010;
        wait_ack(4, "full wr");
        repeat (3) step();
        chk("full only write acked", ack_log.size() - a0, 1);
        if (ack_log.size() > a0) chk("full first ack port", ack_log[a0], 4);
        bus.app_rd_data = rnd128(); bus.app_rd_data_valid = 1;
        step();
        bus.app_rd_data_valid = 0;
        wait_ack(1, "full rd");
        if (ack_log.size() > a0 + 1) chk("full second ack port", ack_log[a0 + 1], 1);

        // overflow, then reset mid-command
        do_reset();
        r0 = rv_log.size();
        bus.app_rd_data_valid = 1;
        step();
        bus.app_rd_data_valid = 0;
        step();
        chk("overflow set", bus.rd_overflow, 1'b1);
        chk("overflow no rd_valid", rv_log.size() - r0, 0);
        bus.app_rdy = 0;
        set_port(4, 1, 27'h1234, rnd128());
        bus.req = 5'b10000;
        step(); step();
        a0 = ack_log.size();
        rst_n = 1'b0;
        #1;
        chk("mid-cmd reset outputs",
            {bus.app_en, bus.app_wdf_wren, bus.ack, bus.rd_overflow, bus.app_cmd, bus.app_addr}, '0);
        bus.req = '0;
        repeat (2) @(posedge ui_clk);
        #1 rst_n = 1'b1;
        bus.app_rdy = 1;
        repeat (5) step();
        chk("no ack after reset", ack_log.size() - a0, 0);

        // grant statistics
        do_reset();
        set_port(0, 1, 27'h10, rnd128());
        repeat (3) begin bus.req[0] = 1; wait_ack(0, "stat"); end
        step();
`ifdef ARB_STATS_EN
        chk("stat port0", bus.stat_grants[15:0], 16'd3);
`else
        chk("stat tied 0", bus.stat_grants, '0);
`endif

        // randomized traffic
        do_reset();
        repeat (3000) begin
            step();
            bus.init_calib_complete = ($urandom_range(0, 19) != 0);
            bus.app_rdy     = ($urandom_range(0, 3) != 0);
            bus.app_wdf_rdy = ($urandom_range(0, 3) != 0);
            bus.app_rd_data = rnd128();
            bus.app_rd_data_valid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
            for (int p = 0; p < NP; p++)
                if (!bus.req[p] && $urandom_range(0, 3) == 0) begin
                    set_port(p, 1'($urandom), AW'($urandom), rnd128());
                    bus.req[p] = 1'b1;
                end
        end
        bus.req = '0;
        bus.app_rd_data_valid = 0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mig_port_arbiter.md
Name: mig_port_arbiter

Overview:
- Parametrised N-port arbiter between pixel-path clients (camera_store, HDR write/read, VGA row buffer, UART) and the MIG 7-series app interface.
- Successor to the fixed five-client request handler. Adds:
  - configurable port count
  - a high-priority class with round-robin arbitration inside each class
  - an outstanding-read tag FIFO, so several reads can be in flight at once
- Read data is routed back to the issuing port.

Parameters:
- NUM_PORTS, 5, number of client ports (2..8)
- DATA_WIDTH, 128, app data width
- ADDR_WIDTH, 27, app address width
- RD_DEPTH, 16, maximum outstanding reads; tag FIFO depth; power of 2
- PRIO_MASK, 5'b00010, bit i set = port i in high-priority class

Ports:
- ui_clk in 1 MIG user clock
- rst_n in 1 asynchronous active-low reset
- init_calib_complete in 1 MIG calibration done; no grants while low
- req in NUM_PORTS per-port request, held until ack
- req_we in NUM_PORTS 1 = write, 0 = read
- req_addr in NUM_PORTS*ADDR_WIDTH per-port address, port i at [i*AW +: AW]
- req_wdata in NUM_PORTS*DATA_WIDTH per-port write data
- ack out NUM_PORTS one-cycle pulse when the port's command (and data, for writes) is accepted
- rd_valid out NUM_PORTS one-cycle pulse, read data for port i
- rd_data out DATA_WIDTH shared read data bus
- app_addr out ADDR_WIDTH; app_cmd out 3 (000 write, 001 read); app_en out 1; app_rdy in 1
- app_wdf_data out DATA_WIDTH; app_wdf_end out 1; app_wdf_wren out 1; app_wdf_mask out DATA_WIDTH/8 (always 0); app_wdf_rdy in 1
- app_rd_data in DATA_WIDTH; app_rd_data_valid in 1; app_rd_data_end in 1 (unused)
- app_hi_pri out 1 (tied 0)
- rd_overflow out 1 sticky error: read data arrived with tag FIFO empty
- stat_grants out NUM_PORTS*16 grant counters (see Optional Feature)

Behaviour:
- Reset:
  - All outputs 0.
  - FSM enters IDLE.
  - Round-robin pointers = 0.
  - Tag FIFO emptied; rd_overflow = 0.
- Reset mid-transaction abandons it: no ack, outstanding tags discarded.
- Eligibility: a port is eligible when req[i]=1, init_calib_complete=1, and either req_we[i]=1 or the tag FIFO is not full. Writes stay eligible while the FIFO is full.
- Arbitration:
  - Performed in IDLE only.
  - If any high-priority port is eligible, pick among high-priority ports; otherwise among low-priority ports.
  - Within a class, pick the first eligible port at or after that class's pointer, wrapping modulo NUM_PORTS.
  - After a grant, the class pointer = granted index + 1, with wrap.
- FSM:
  - IDLE -> CMD on a grant. Register the port index, cmd, addr and wdata.
  - In CMD:
    - app_en=1 until a cycle with app_en & app_rdy; set cmd_done.
    - For writes, app_wdf_wren=app_wdf_end=1 until a cycle with app_wdf_rdy; set wdf_done. Reads set wdf_done=1 on entry.
    - Command and data may be accepted in either order or in the same cycle.
  - CMD -> IDLE in the cycle after both done flags are set. ack[idx] pulses in that transition cycle.
  - Minimum 3 cycles grant-to-grant.
- Read tagging:
  - On read command acceptance (app_en & app_rdy & cmd=read), push idx into the tag FIFO.
  - On app_rd_data_valid, pop the FIFO. One cycle later, rd_valid[tag]=1 and rd_data = registered app_rd_data.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - app_rd_data_valid with the FIFO empty: no rd_valid, rd_overflow set until reset.
- Read data returns in MIG order. Each port sees its own reads in issue order.
- No req held = no activity. Deasserting req before ack is illegal; the registered command completes regardless.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Per-port 16-bit grant counters, incremented on ack[i], saturating at 16'hFFFF.
  - Driven on stat_grants[i*16 +: 16]; cleared only by rst_n.
- Undefined: stat_grants tied 0, no counter logic.

Test Plan:
- Calibration gate: init_calib_complete=0, req=5'b00001 -> no app_en. Raise calib -> app_en with app_cmd=001, app_addr=req_addr[0] within 2 cycles.
- Priority and round-robin: ports 0, 2, 3, 4 request continuously, port 1 (PRIO) pulses once with app_rdy=app_wdf_rdy=1. Required grant order 0, 1, 2, 3, 4, 0: port 1 served at the next IDLE after its request, then low-class round-robin resumes at port 2.
- Write handshake order: port 2 write, addr 27'h100, data 128'hA5..A5. app_wdf_rdy=1 three cycles before app_rdy -> ack[2] exactly one cycle after app_rdy acceptance; wdf_wren seen once.
- Read routing: reads from ports 3, 0, 3 issued, then app_rd_data_valid with data D1, D2, D3 -> rd_valid pattern 5'b01000, 5'b00001, 5'b01000 with D1..D3, each one cycle after its valid.
- FIFO full: RD_DEPTH=4, four reads outstanding. Port 1 read stalls while a port 4 write is granted. First returned data frees a slot -> port 1 granted.
- Overflow and reset: app_rd_data_valid with nothing outstanding -> rd_overflow=1, no rd_valid. Assert rst_n=0 mid-CMD -> all outputs 0 immediately, no ack after release.
- With ARB_STATS_EN, 3 acks to port 0 -> stat_grants[15:0]=3.
